// File: rtl/fft_pkg.sv
// Shared FFT/IFFT datapath types: lane count, sample type and saturating negate.
package fft_pkg;

   localparam int LANES = 16;
   localparam int WIDTH = 12;

   typedef logic signed [WIDTH-1:0] sample_t;

   localparam sample_t SAT_MAX = sample_t'({1'b0, {(WIDTH-1){1'b1}}});
   localparam sample_t SAT_MIN = sample_t'({1'b1, {(WIDTH-1){1'b0}}});

   typedef struct packed {
      sample_t value;
      logic    sat;
   } neg_t;

   // The most negative code has no positive twin, so it clamps to SAT_MAX.
   function automatic neg_t sat_neg(sample_t x);
      neg_t r;
      if (x == SAT_MIN) begin
         r.value = SAT_MAX;
         r.sat   = 1'b1;
      end else begin
         r.value = -x;
         r.sat   = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/itwd_mul10_if.sv
// One beat of butterfly lanes: valid/sof framing plus 16 sum and 16 diff samples.
interface itwd_mul10_if;
   import fft_pkg::*;

   logic    valid;
   logic    sof;
   sample_t sum_re  [LANES];
   sample_t sum_im  [LANES];
   sample_t diff_re [LANES];
   sample_t diff_im [LANES];

   modport master (output valid, sof, sum_re, sum_im, diff_re, diff_im);
   modport slave  (input  valid, sof, sum_re, sum_im, diff_re, diff_im);

endinterface

// File: rtl/itwd_lane.sv
// One diff lane: optional +j rotation (re' = -im, im' = re) with saturating negate.
module itwd_lane
   import fft_pkg::*;
(
   input  logic    rot,
   input  sample_t diff_re,
   input  sample_t diff_im,
   output sample_t rot_re,
   output sample_t rot_im,
   output logic    sat
);

   neg_t neg_im;

   assign neg_im = sat_neg(diff_im);

   always_comb begin
      rot_re = diff_re;
      rot_im = diff_im;
      sat    = 1'b0;
      if (rot) begin
         rot_re = neg_im.value;
         rot_im = diff_re;
         sat    = neg_im.sat;
      end
   end

endmodule

// File: rtl/itwd_mul10.sv
// IFFT "10" stage twiddle: diff lanes rotated by +j on odd beats, one register stage,
// phase counter restarted by sof, sticky saturation flag.
module itwd_mul10
   import fft_pkg::*;
#(
   parameter int CLK_CNT = 4
) (
   input  logic               clk,
   input  logic               rstn,
   itwd_mul10_if.slave        i_beat,
   itwd_mul10_if.master       o_beat,
   output logic               o_blk_done,
   output logic               o_sat
);

   localparam logic [CLK_CNT-1:0] PHASE_LAST = '1;

   logic [CLK_CNT-1:0] phase_reg;
   logic [CLK_CNT-1:0] phase_next;
   logic [CLK_CNT-1:0] beat_phase;
   logic [LANES-1:0]   lane_sat;
   logic               valid_reg;
   logic               sof_reg;
   logic               blk_done_reg;
   logic               sat_reg;

   // A sof beat is phase 0 regardless of where the counter was, abandoning any open block.
   always_comb begin
      beat_phase = i_beat.sof ? '0 : phase_reg;
      phase_next = phase_reg;
      if (i_beat.valid) begin
         phase_next = beat_phase + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_reg    <= '0;
         valid_reg    <= 1'b0;
         sof_reg      <= 1'b0;
         blk_done_reg <= 1'b0;
         sat_reg      <= 1'b0;
      end else begin
         phase_reg    <= phase_next;
         valid_reg    <= i_beat.valid;
         sof_reg      <= i_beat.valid & i_beat.sof;
         blk_done_reg <= i_beat.valid && (beat_phase == PHASE_LAST);
         if (i_beat.valid && (|lane_sat)) begin
            sat_reg <= 1'b1;
         end
      end
   end

   assign o_beat.valid = valid_reg;
   assign o_beat.sof   = sof_reg;
   assign o_blk_done   = blk_done_reg;
   assign o_sat        = sat_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         sample_t rot_re;
         sample_t rot_im;
         sample_t sum_re_reg;
         sample_t sum_im_reg;
         sample_t diff_re_reg;
         sample_t diff_im_reg;

         itwd_lane u_lane (
            .rot     (beat_phase[0]),
            .diff_re (i_beat.diff_re[gi]),
            .diff_im (i_beat.diff_im[gi]),
            .rot_re  (rot_re),
            .rot_im  (rot_im),
            .sat     (lane_sat[gi])
         );

         // Data registers only load on valid beats so outputs hold across gaps.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               sum_re_reg  <= '0;
               sum_im_reg  <= '0;
               diff_re_reg <= '0;
               diff_im_reg <= '0;
            end else if (i_beat.valid) begin
               sum_re_reg  <= i_beat.sum_re[gi];
               sum_im_reg  <= i_beat.sum_im[gi];
               diff_re_reg <= rot_re;
               diff_im_reg <= rot_im;
            end
         end

         assign o_beat.sum_re[gi]  = sum_re_reg;
         assign o_beat.sum_im[gi]  = sum_im_reg;
         assign o_beat.diff_re[gi] = diff_re_reg;
         assign o_beat.diff_im[gi] = diff_im_reg;
      end
   endgenerate

endmodule

// File: tb/tb_itwd_mul10.sv
// Directed bench for itwd_mul10: reset, full blocks, gaps, restart, saturation, async reset.
module tb_itwd_mul10;
   import fft_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   logic o_blk_done;
   logic o_sat;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   itwd_mul10_if i_bus ();
   itwd_mul10_if o_bus ();

   itwd_mul10 #(.CLK_CNT(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_beat     (i_bus),
      .o_beat     (o_bus),
      .o_blk_done (o_blk_done),
      .o_sat      (o_sat)
   );

   task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Lane 0 carries the stimulus; lane 15 carries a fixed diff (-7,300) and sum (-1000,1000).
   task automatic drive(logic v, logic s, int dre, int dim);
      i_bus.valid      = v;
      i_bus.sof        = s;
      i_bus.diff_re[0] = sample_t'(dre);
      i_bus.diff_im[0] = sample_t'(dim);
      i_bus.sum_re[0]  = sample_t'(dim);
      i_bus.sum_im[0]  = sample_t'(dre);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_chk(string tag, int idx, logic v, logic s, logic d,
                           int ore, int oim, int sre, int sim, logic rot15);
      string t;
      t = $sformatf("%s[%0d]", tag, idx);
      $display("beat %s valid=%0b sof=%0b done=%0b diff0=(%0d,%0d) sat=%0b", t,
               o_bus.valid, o_bus.sof, o_blk_done, o_bus.diff_re[0], o_bus.diff_im[0], o_sat);
      chk({t, " valid"},    32'(o_bus.valid), 32'(v));
      chk({t, " sof"},      32'(o_bus.sof),   32'(s));
      chk({t, " blk_done"}, 32'(o_blk_done),  32'(d));
      chk({t, " diff0_re"}, 32'(o_bus.diff_re[0]), ore);
      chk({t, " diff0_im"}, 32'(o_bus.diff_im[0]), oim);
      chk({t, " sum0_re"},  32'(o_bus.sum_re[0]),  sre);
      chk({t, " sum0_im"},  32'(o_bus.sum_im[0]),  sim);
      chk({t, " diff15_re"}, 32'(o_bus.diff_re[15]), rot15 ? -300 : -7);
      chk({t, " diff15_im"}, 32'(o_bus.diff_im[15]), rot15 ? -7 : 300);
      chk({t, " sum15_re"},  32'(o_bus.sum_re[15]), -1000);
   endtask

   initial begin
      for (int i = 0; i < LANES; i++) begin
         i_bus.sum_re[i]  = '0;
         i_bus.sum_im[i]  = '0;
         i_bus.diff_re[i] = '0;
         i_bus.diff_im[i] = '0;
      end
      i_bus.diff_re[15] = sample_t'(-7);
      i_bus.diff_im[15] = sample_t'(300);
      i_bus.sum_re[15]  = sample_t'(-1000);
      i_bus.sum_im[15]  = sample_t'(1000);
      rstn = 1'b0;
      drive(1'b0, 1'b0, 0, 0);
      repeat (2) tick();

      // Reset state
      $display("reset state check");
      chk("rst valid",    32'(o_bus.valid), 0);
      chk("rst sof",      32'(o_bus.sof), 0);
      chk("rst blk_done", 32'(o_blk_done), 0);
      chk("rst sat",      32'(o_sat), 0);
      chk("rst diff0_re", 32'(o_bus.diff_re[0]), 0);
      chk("rst sum15_re", 32'(o_bus.sum_re[15]), 0);

      rstn = 1'b1;
      tick();
      chk("idle valid", 32'(o_bus.valid), 0);

      // Two back-to-back blocks: sof at beats 0 and 16, blk_done at 15 and 31
      for (int b = 0; b < 32; b++) begin
         drive(1'b1, (b % 16) == 0, 100, -50);
         tick();
         beat_chk("blk", b, 1'b1, (b % 16) == 0, (b % 16) == 15,
                  (b % 2) ? 50 : 100, (b % 2) ? 100 : -50, -50, 100, (b % 2) == 1);
      end
      drive(1'b0, 1'b0, 0, 0);
      tick();
      beat_chk("post", 0, 1'b0, 1'b0, 1'b0, 50, 100, -50, 100, 1'b1);

      // Gaps 1,0,0,1 with a stray sof while idle: phase must hold
      drive(1'b1, 1'b0, 10, 20);
      tick();
      beat_chk("gap", 0, 1'b1, 1'b0, 1'b0, 10, 20, 20, 10, 1'b0);
      drive(1'b0, 1'b1, 999, 888);
      tick();
      beat_chk("gap", 1, 1'b0, 1'b0, 1'b0, 10, 20, 20, 10, 1'b0);
      tick();
      beat_chk("gap", 2, 1'b0, 1'b0, 1'b0, 10, 20, 20, 10, 1'b0);
      drive(1'b1, 1'b0, 10, 20);
      tick();
      beat_chk("gap", 3, 1'b1, 1'b0, 1'b0, -20, 10, 20, 10, 1'b1);

      // Phases 2,3,4 then sof restart mid-block
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 1, 2);
         tick();
         beat_chk("pre", k, 1'b1, 1'b0, 1'b0,
                  (k == 1) ? -2 : 1, (k == 1) ? 1 : 2, 2, 1, k == 1);
      end
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, k == 0, 1, 2);
         tick();
         beat_chk("restart", k, 1'b1, k == 0, k == 15,
                  (k % 2) ? -2 : 1, (k % 2) ? 1 : 2, 2, 1, (k % 2) == 1);
      end

      // Saturation: only the negated path may saturate; o_sat is sticky
      chk("sat before", 32'(o_sat), 0);
      drive(1'b1, 1'b0, 5, -2048);
      tick();
      beat_chk("sat", 0, 1'b1, 1'b0, 1'b0, 5, -2048, -2048, 5, 1'b0);
      chk("sat[0] flag", 32'(o_sat), 0);
      drive(1'b1, 1'b0, 5, -2048);
      tick();
      beat_chk("sat", 1, 1'b1, 1'b0, 1'b0, 2047, 5, -2048, 5, 1'b1);
      chk("sat[1] flag", 32'(o_sat), 1);
      drive(1'b1, 1'b0, -2048, 3);
      tick();
      beat_chk("sat", 2, 1'b1, 1'b0, 1'b0, -2048, 3, 3, -2048, 1'b0);
      chk("sat[2] flag", 32'(o_sat), 1);
      drive(1'b1, 1'b0, -2048, 3);
      tick();
      beat_chk("sat", 3, 1'b1, 1'b0, 1'b0, -3, -2048, 3, -2048, 1'b1);
      chk("sat[3] flag", 32'(o_sat), 1);
      drive(1'b0, 1'b0, 0, 0);
      tick();
      chk("sat idle flag", 32'(o_sat), 1);

      // Asynchronous reset while streaming
      drive(1'b1, 1'b0, 40, 60);
      tick();
      beat_chk("pre_rst", 0, 1'b1, 1'b0, 1'b0, 40, 60, 60, 40, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      $display("async reset check");
      chk("arst valid",    32'(o_bus.valid), 0);
      chk("arst sat",      32'(o_sat), 0);
      chk("arst diff0_re", 32'(o_bus.diff_re[0]), 0);
      chk("arst diff0_im", 32'(o_bus.diff_im[0]), 0);
      chk("arst sum0_re",  32'(o_bus.sum_re[0]), 0);
      chk("arst diff15_im", 32'(o_bus.diff_im[15]), 0);
      tick();
      chk("arst hold valid", 32'(o_bus.valid), 0);
      rstn = 1'b1;
      drive(1'b1, 1'b1, 100, -50);
      tick();
      beat_chk("after_rst", 0, 1'b1, 1'b1, 1'b0, 100, -50, -50, 100, 1'b0);
      drive(1'b1, 1'b0, 100, -50);
      tick();
      beat_chk("after_rst", 1, 1'b1, 1'b0, 1'b0, 50, 100, -50, 100, 1'b1);
      chk("after_rst sat", 32'(o_sat), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
